// File: rtl/hero_cmd_sched.sv
// hero_cmd_sched: button edge detector, fixed-priority arbiter and command FIFO for the hero engine.
// Defining HERO_CMD_REPEAT_EN adds auto-repeat of a held direction button every REPEAT_CYCLES cycles.
module hero_cmd_sched #(
   parameter int unsigned DEPTH         = 4,
   parameter logic [23:0] REPEAT_CYCLES = 24'd6_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     up,
   input  logic                     left,
   input  logic                     right,
   input  logic                     down,
   input  logic                     center,
   input  logic                     cmd_ready,
   input  logic                     clr_ovf,
   output logic                     cmd_valid,
   output logic [2:0]               cmd_code,
   output logic [2:0]               last_dir,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [2:0] CODE_NONE   = 3'b000;
   localparam logic [2:0] CODE_UP     = 3'b010;
   localparam logic [2:0] CODE_LEFT   = 3'b011;
   localparam logic [2:0] CODE_RIGHT  = 3'b100;
   localparam logic [2:0] CODE_DOWN   = 3'b101;
   localparam logic [2:0] CODE_ATTACK = 3'b110;

   typedef enum logic {ST_EMPTY = 1'b0, ST_PRESENT = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [4:0]      prev_q;
   logic [4:0]      btn, rise;
   logic [2:0]      edge_code, new_code;
   logic [2:0]      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   level_q, level_d;
   logic [2:0]      code_q, code_d, last_q, last_d;
   logic            ovf_q, ovf_d;
   logic            push_req, push_ok, pop, full, drop;
   logic [AW-1:0]   wr_addr, rd_addr_d;

   assign btn  = {up, left, right, down, center};
   assign rise = btn & ~prev_q;

   // Fixed priority; losing edges in the same cycle are discarded.
   always_comb begin
      edge_code = CODE_NONE;
      if      (rise[4]) edge_code = CODE_UP;
      else if (rise[3]) edge_code = CODE_LEFT;
      else if (rise[2]) edge_code = CODE_RIGHT;
      else if (rise[1]) edge_code = CODE_DOWN;
      else if (rise[0]) edge_code = CODE_ATTACK;
   end

`ifdef HERO_CMD_REPEAT_EN
   logic [2:0]  held_code, held_q;
   logic [23:0] rpt_cnt_q, rpt_cnt_d;
   logic        rpt_arm_q, rpt_arm_d, rpt_fire;

   always_comb begin
      held_code = CODE_NONE;
      if      (up)    held_code = CODE_UP;
      else if (left)  held_code = CODE_LEFT;
      else if (right) held_code = CODE_RIGHT;
      else if (down)  held_code = CODE_DOWN;
   end

   // Repeat only arms when the top held direction was itself just pressed.
   always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_arm_d = rpt_arm_q;
      rpt_fire  = 1'b0;
      if ((rise != 5'b0) || (held_code != held_q) || (held_code == CODE_NONE)) begin
         rpt_cnt_d = 24'd0;
         rpt_arm_d = (rise != 5'b0) && (edge_code == held_code) && (held_code != CODE_NONE);
      end else if (rpt_arm_q) begin
         if (rpt_cnt_q == REPEAT_CYCLES - 24'd1) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = 24'd0;
         end else begin
            rpt_cnt_d = rpt_cnt_q + 24'd1;
         end
      end
   end

   assign new_code = (edge_code != CODE_NONE) ? edge_code : (rpt_fire ? held_code : CODE_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt_q <= 24'd0;
         rpt_arm_q <= 1'b0;
         held_q    <= CODE_NONE;
      end else begin
         rpt_cnt_q <= rpt_cnt_d;
         rpt_arm_q <= rpt_arm_d;
         held_q    <= held_code;
      end
   end
`else
   logic unused_repeat_cycles;

   assign new_code             = edge_code;
   assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

   assign wr_addr = wr_ptr_q[AW-1:0];

   // FIFO bookkeeping, registered head/last_dir/overflow, and output-state FSM.
   always_comb begin
      state_d   = state_q;
      push_req  = (new_code != CODE_NONE);
      pop       = (state_q == ST_PRESENT) && cmd_ready;
      full      = (level_q == PW'(DEPTH));
      push_ok   = push_req && (!full || pop);
      drop      = push_req && full && !pop;
      wr_ptr_d  = wr_ptr_q + PW'(push_ok);
      rd_ptr_d  = rd_ptr_q + PW'(pop);
      level_d   = wr_ptr_d - rd_ptr_d;
      rd_addr_d = rd_ptr_d[AW-1:0];
      code_d    = CODE_NONE;
      if (level_d != '0) begin
         code_d = (push_ok && (wr_addr == rd_addr_d)) ? new_code : mem_q[rd_addr_d];
      end
      last_d = last_q;
      if (pop && (code_q >= CODE_UP) && (code_q <= CODE_DOWN)) last_d = code_q;
      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
      case (state_q)
         ST_EMPTY:   if (push_ok)          state_d = ST_PRESENT;
         ST_PRESENT: if (level_d == '0)    state_d = ST_EMPTY;
         default:                          state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         prev_q   <= 5'b11111;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         code_q   <= CODE_NONE;
         last_q   <= CODE_NONE;
         ovf_q    <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= CODE_NONE;
      end else begin
         state_q  <= state_d;
         prev_q   <= btn;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         code_q   <= code_d;
         last_q   <= last_d;
         ovf_q    <= ovf_d;
         if (push_ok) mem_q[wr_addr] <= new_code;
      end
   end

   assign cmd_valid = (state_q == ST_PRESENT);
   assign cmd_code  = code_q;
   assign last_dir  = last_q;
   assign level     = level_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_hero_cmd_sched.sv
// Bench for hero_cmd_sched: queue-based reference model checked every cycle plus literal expectations.
module tb_hero_cmd_sched;

   localparam int unsigned DEPTH = 4;
   localparam int          RPT   = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up, left, right, down, center, cmd_ready, clr_ovf;
   logic       cmd_valid;
   logic [2:0] cmd_code, last_dir;
   logic [2:0] level;
   logic       overflow;

   int n_pass  = 0;
   int n_total = 0;

   hero_cmd_sched #(.DEPTH(DEPTH), .REPEAT_CYCLES(24'd10)) dut (
      .clk(clk), .rst_n(rst_n), .up(up), .left(left), .right(right), .down(down),
      .center(center), .cmd_ready(cmd_ready), .clr_ovf(clr_ovf), .cmd_valid(cmd_valid),
      .cmd_code(cmd_code), .last_dir(last_dir), .level(level), .overflow(overflow));

   always #5 clk = ~clk;

   // Reference model state
   logic [2:0] m_q[$];
   logic [4:0] m_prev;
   logic [2:0] m_last;
   logic       m_ovf;
   logic [2:0] m_hd_prev;
   logic       m_armed;
   int         m_run;
   logic [2:0] exp_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_prev    = 5'b11111;
      m_last    = 3'b000;
      m_ovf     = 1'b0;
      m_hd_prev = 3'b000;
      m_armed   = 1'b0;
      m_run     = 0;
   endtask

   task automatic model_step();
      logic [4:0] btn, rise;
      logic [2:0] gen, hd;
      logic       pop;
      btn  = {up, left, right, down, center};
      rise = btn & ~m_prev;
      m_prev = btn;
      gen = 3'b000;
      if      (rise[4]) gen = 3'b010;
      else if (rise[3]) gen = 3'b011;
      else if (rise[2]) gen = 3'b100;
      else if (rise[1]) gen = 3'b101;
      else if (rise[0]) gen = 3'b110;
      hd = up ? 3'b010 : left ? 3'b011 : right ? 3'b100 : down ? 3'b101 : 3'b000;
`ifdef HERO_CMD_REPEAT_EN
      if (rise != 5'b0 || hd != m_hd_prev || hd == 3'b000) begin
         m_run   = 0;
         m_armed = (rise != 5'b0) && (gen == hd) && (hd != 3'b000);
      end else if (m_armed) begin
         m_run++;
         if (m_run == RPT) begin
            gen   = hd;
            m_run = 0;
         end
      end
`endif
      m_hd_prev = hd;
      pop = (m_q.size() != 0) && cmd_ready;
      if (pop) begin
         if (m_q[0] >= 3'b010 && m_q[0] <= 3'b101) m_last = m_q[0];
         void'(m_q.pop_front());
      end
      if (clr_ovf) m_ovf = 1'b0;
      if (gen != 3'b000) begin
         if (m_q.size() == int'(DEPTH)) m_ovf = 1'b1;
         else m_q.push_back(gen);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
         #1;
      end
   endtask

   task automatic press(input logic [4:0] m);
      {up, left, right, down, center} = m;
      tick(1);
      {up, left, right, down, center} = 5'b0;
      tick(1);
   endtask

   always @(negedge clk) begin
      exp_code = (m_q.size() != 0) ? m_q[0] : 3'b000;
      check("cmd_valid", 32'(cmd_valid), 32'(m_q.size() != 0));
      check("cmd_code", 32'(cmd_code), 32'(exp_code));
      check("level", 32'(level), 32'(m_q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("last_dir", 32'(last_dir), 32'(m_last));
   end

   initial begin
      rst_n = 1'b0;
      {up, left, right, down, center} = 5'b0;
      cmd_ready = 1'b0;
      clr_ovf   = 1'b0;
      model_reset();
      tick(2);
      check("reset_valid", 32'(cmd_valid), 32'd0);
      check("reset_level", 32'(level), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Single press, held head while engine is busy
      up = 1'b1;
      tick(1);
      up = 1'b0;
      check("up_valid", 32'(cmd_valid), 32'd1);
      check("up_code", 32'(cmd_code), 32'h2);
      check("up_level", 32'(level), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("up_hold", 32'(cmd_code), 32'h2);
      end
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      check("up_drained", 32'(level), 32'd0);

      // Simultaneous left and down
      press(5'b01010);
      check("prio_level", 32'(level), 32'd1);
      check("prio_code", 32'(cmd_code), 32'h3);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;

      // Overflow on the fifth press, ordered drain, clear
      press(5'b10000); press(5'b01000); press(5'b00100); press(5'b00010); press(5'b00001);
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head", 32'(cmd_code), 32'h2);
      cmd_ready = 1'b1;
      tick(1); check("drain1", 32'(cmd_code), 32'h3);
      tick(1); check("drain2", 32'(cmd_code), 32'h4);
      tick(1); check("drain3", 32'(cmd_code), 32'h5);
      tick(1); check("drain_empty", 32'(cmd_valid), 32'd0);
      cmd_ready = 1'b0;
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("ovf_clear", 32'(overflow), 32'd0);

      // last_dir ignores ATTACK pops
      press(5'b00100); press(5'b00001);
      cmd_ready = 1'b1;
      tick(1); check("last_right", 32'(last_dir), 32'h4);
      tick(1); check("last_after_atk", 32'(last_dir), 32'h4);
      cmd_ready = 1'b0;

      // Full FIFO with simultaneous push and pop
      press(5'b10000); press(5'b01000); press(5'b00100); press(5'b00010);
      cmd_ready = 1'b1;
      center = 1'b1;
      tick(1);
      center = 1'b0;
      cmd_ready = 1'b0;
      check("pp_level", 32'(level), 32'd4);
      check("pp_ovf", 32'(overflow), 32'd0);
      check("pp_head", 32'(cmd_code), 32'h3);
      cmd_ready = 1'b1;
      tick(2);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_code", 32'(cmd_code), 32'd0);
      check("rst_last", 32'(last_dir), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      cmd_ready = 1'b0;
      down = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("held_thru_rst", 32'(level), 32'd0);
      down = 1'b0;
      tick(2);

      // Long hold of down
      down = 1'b1;
      tick(35);
      down = 1'b0;
      tick(2);
`ifdef HERO_CMD_REPEAT_EN
      check("hold_level", 32'(level), 32'd4);
`else
      check("hold_level", 32'(level), 32'd1);
`endif
      check("hold_head", 32'(cmd_code), 32'h5);
      cmd_ready = 1'b1;
      tick(4);
      check("final_empty", 32'(level), 32'd0);
      cmd_ready = 1'b0;
      tick(1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hero_cmd_sched.md
# hero_cmd_sched

Command scheduler between the board push-buttons and the hero movement engine. It detects button presses, resolves simultaneous presses by fixed priority, and buffers the resulting commands in a small FIFO. It issues commands one at a time over a valid/ready handshake and tracks the last accepted movement direction so the engine can aim attacks. It replaces direct level-wiring of buttons into the engine, so no press is lost while a 60-step move is in progress.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `REPEAT_CYCLES`, 24'd6_000_000, hold time before an auto-repeat enqueue; used only with `HERO_CMD_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `up`, `left`, `right`, `down`, `center`  in  1 each  button levels, already synchronised and debounced.
- `cmd_ready`  in  1  engine can accept a command (engine idle).
- `clr_ovf`  in  1  clears `overflow`.
- `cmd_valid`  out  1  FIFO head is valid.
- `cmd_code`  out  3  head command: UP=3'b010, LEFT=3'b011, RIGHT=3'b100, DOWN=3'b101, ATTACK=3'b110; 3'b000 when not valid.
- `last_dir`  out  3  code of the last accepted movement command; 3'b000 until the first one.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; set when a command is dropped because the FIFO is full.

## Operation
- Edge detect: a command is generated when a button goes from low on the previous cycle to high on the current cycle.
- Previous-state registers reset to all 1s. A button held through reset release therefore generates nothing until it is released and pressed again.
- Priority, one command per cycle: up > left > right > down > center. Other rising edges in the same cycle are discarded, not deferred.
- FIFO is a circular buffer with read/write pointers one bit wider than the address; pointers wrap modulo 2·DEPTH.
- Push on a generated command. Pop on `cmd_valid && cmd_ready`.
- Full with no pop: the push is dropped, `overflow` is set, and stored entries are unchanged.
- Full with a pop in the same cycle: the push is accepted and `level` is unchanged.
- Empty: no bypass. A push becomes visible on the next cycle.
- `last_dir` updates on a pop of a movement code (0b010–0b101) only. ATTACK pops leave it unchanged.
- `overflow` is cleared by `clr_ovf`. If `clr_ovf` and a drop happen in the same cycle, set wins.
- Output states:
  - EMPTY (`cmd_valid` = 0): moves to PRESENT on a push.
  - PRESENT (`cmd_valid` = 1): returns to EMPTY when a pop leaves `level` = 0.
  - `cmd_code` must not change while `cmd_valid` = 1 and `cmd_ready` = 0.

## Timing
- Rising edge sampled at clock edge k → entry written at k → `cmd_valid`/`cmd_code` valid after edge k (1-cycle latency from button to output).
- Pop at edge k → next entry presented after edge k. Back-to-back pops are sustained at one per cycle.
- `last_dir` updates at the pop edge.
- `overflow` is set at the drop edge.
- Reset (asynchronous, immediate):
  - `cmd_valid` = 0, `cmd_code` = 0, `last_dir` = 0, `level` = 0, `overflow` = 0.
  - Pointers = 0; repeat counter = 0.
  - Reset mid-operation discards all queued commands.

## Configuration
- `HERO_CMD_REPEAT_EN` defined:
  - While the highest-priority direction button stays continuously high after its edge, a counter increments each cycle.
  - At `REPEAT_CYCLES` the same code is pushed, under the same full/overflow rules, and the counter restarts.
  - The counter clears on release, on a change of the highest-held direction, or on any new rising edge.
  - `center` never repeats.
- Undefined: commands are generated on rising edges only. The counter logic and `REPEAT_CYCLES` are unused.

## Test plan
- Reset, then pulse `up` with `cmd_ready` = 0 → after 1 cycle `cmd_valid` = 1, `cmd_code` = 3'b010, `level` = 1; code is held stable for 10 cycles.
- Rising edges on `left` and `down` in the same cycle → only 3'b011 is enqueued; `level` = 1.
- `cmd_ready` = 0, 5 distinct presses with DEPTH = 4 → `level` = 4, `overflow` = 1, FIFO holds the first 4 codes. Raising `cmd_ready` drains them in order over 4 cycles. `clr_ovf` pulse → `overflow` = 0.
- Queue RIGHT then ATTACK with `cmd_ready` = 1 → `last_dir` = 3'b100 after the first pop and stays 3'b100 after the ATTACK pop.
- FIFO full, push and pop in the same cycle → `level` stays 4, `overflow` stays 0, new code lands at the tail. Assert `rst_n` = 0 mid-drain → all outputs 0 immediately. Hold `down` across reset release → no command.
- `HERO_CMD_REPEAT_EN` with `REPEAT_CYCLES` = 10, hold `down` 35 cycles → 4 DOWN entries (edge + 3 repeats). Same stimulus without the macro → 1 entry.
